// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two valid/ready requesters.
// Optional `ALU_OPCHECK_EN adds per-port rN_err outputs and keeps unknown ops off the ALU.
module alu_arbiter #(
  parameter int             WIDTH   = 32,
  parameter int             OPW     = 3,
  parameter logic [OPW-1:0] IDLE_OP = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [OPW-1:0]   r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  output logic             r0_resp_valid,
  input  logic             r0_resp_ready,
  output logic [WIDTH-1:0] r0_result,
  output logic             r0_zero,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [OPW-1:0]   r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             r1_resp_valid,
  input  logic             r1_resp_ready,
  output logic [WIDTH-1:0] r1_result,
  output logic             r1_zero,
`ifdef ALU_OPCHECK_EN
  output logic             r0_err,
  output logic             r1_err,
`endif
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_gnt_q, last_gnt_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] result_q [2];
  logic [WIDTH-1:0] result_d [2];
  logic [1:0]       zero_q, zero_d;

  logic             sel;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [1:0]       resp_ready_vec;

`ifdef ALU_OPCHECK_EN
  logic             bad_q, bad_d;
  logic [1:0]       err_q, err_d;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return (op == OPW'(3'b001)) || (op == OPW'(3'b010)) ||
           (op == OPW'(3'b101)) || (op == OPW'(3'b111));
  endfunction
`endif

  // Both valid: grant the port that was not served last; otherwise grant the only requester.
  assign sel            = r1_valid & (~r0_valid | ~last_gnt_q);
  assign sel_op         = sel ? r1_op : r0_op;
  assign sel_a          = sel ? r1_a  : r0_a;
  assign sel_b          = sel ? r1_b  : r0_b;
  assign resp_ready_vec = {r1_resp_ready, r0_resp_ready};

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_gnt_d   = last_gnt_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;
    zero_d       = zero_q;
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;
`ifdef ALU_OPCHECK_EN
    bad_d        = bad_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (r0_valid || r1_valid) begin
          r0_ready = ~sel;
          r1_ready = sel;
          gnt_d    = sel;
          alu_op_d = sel_op;
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          state_d  = S_EXEC;
`ifdef ALU_OPCHECK_EN
          if (!op_legal(sel_op)) begin
            alu_op_d = IDLE_OP;
            alu_a_d  = '0;
            alu_b_d  = '0;
            bad_d    = 1'b1;
          end else begin
            bad_d      = 1'b0;
            err_d[sel] = 1'b0;
          end
`endif
        end
      end
      S_EXEC: begin
        result_d[gnt_q]     = alu_result;
        zero_d[gnt_q]       = alu_zero;
        resp_valid_d[gnt_q] = 1'b1;
        state_d             = S_RESP;
`ifdef ALU_OPCHECK_EN
        if (bad_q) begin
          result_d[gnt_q] = '0;
          zero_d[gnt_q]   = 1'b1;
          err_d[gnt_q]    = 1'b1;
        end
`endif
      end
      S_RESP: begin
        // A request arriving in this cycle waits for the next IDLE cycle.
        if (resp_ready_vec[gnt_q]) begin
          resp_valid_d[gnt_q] = 1'b0;
          last_gnt_d          = gnt_q;
          alu_op_d            = IDLE_OP;
          alu_a_d             = '0;
          alu_b_d             = '0;
          state_d             = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gnt_q        <= 1'b0;
      last_gnt_q   <= 1'b1;
      alu_op_q     <= IDLE_OP;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      resp_valid_q <= '0;
      result_q[0]  <= '0;
      result_q[1]  <= '0;
      zero_q       <= '0;
`ifdef ALU_OPCHECK_EN
      bad_q        <= 1'b0;
      err_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_gnt_q   <= last_gnt_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
`ifdef ALU_OPCHECK_EN
      bad_q        <= bad_d;
      err_q        <= err_d;
`endif
    end
  end

  assign alu_op        = alu_op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign r0_resp_valid = resp_valid_q[0];
  assign r1_resp_valid = resp_valid_q[1];
  assign r0_result     = result_q[0];
  assign r1_result     = result_q[1];
  assign r0_zero       = zero_q[0];
  assign r1_zero       = zero_q[1];
`ifdef ALU_OPCHECK_EN
  assign r0_err        = err_q[0];
  assign r1_err        = err_q[1];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to its alu_* ports.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        r0_valid, r0_ready, r0_resp_valid, r0_resp_ready, r0_zero;
  logic [2:0]  r0_op;
  logic [31:0] r0_a, r0_b, r0_result;
  logic        r1_valid, r1_ready, r1_resp_valid, r1_resp_ready, r1_zero;
  logic [2:0]  r1_op;
  logic [31:0] r1_a, r1_b, r1_result;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
`ifdef ALU_OPCHECK_EN
  logic        r0_err, r1_err;
`endif

  int checks;
  int failures;

  alu_arbiter #(.WIDTH(32), .OPW(3), .IDLE_OP(3'b000)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
    .r0_result(r0_result), .r0_zero(r0_zero),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
    .r1_result(r1_result), .r1_zero(r1_zero),
`ifdef ALU_OPCHECK_EN
    .r0_err(r0_err), .r1_err(r1_err),
`endif
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Reference ALU: unsigned slt, wrapping add/sub, unknown op gives 0.
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      3'b001: alu_result = alu_a + alu_b;
      3'b010: alu_result = alu_a | alu_b;
      3'b101: alu_result = alu_a - alu_b;
      3'b111: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v0, v1;
    logic [2:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        g;
    logic [31:0] res;
    logic        z;
    logic        err;
  } vec_t;

  localparam int NV = 13;
  vec_t        tbl [NV];
  logic [31:0] last_res [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int i);
    vec_t        v;
    logic [2:0]  exp_op;
    logic [31:0] exp_a;
    v = tbl[i];
    r0_valid = v.v0; r0_op = v.op0; r0_a = v.a0; r0_b = v.b0;
    r1_valid = v.v1; r1_op = v.op1; r1_a = v.a1; r1_b = v.b1;
    exp_op = v.g ? v.op1 : v.op0;
    exp_a  = v.g ? v.a1 : v.a0;
`ifdef ALU_OPCHECK_EN
    if (v.err) begin
      exp_op = 3'b000;
      exp_a  = 32'd0;
    end
`endif
    @(negedge clk);
    chk($sformatf("v%0d ready_granted", i), {31'd0, v.g ? r1_ready : r0_ready}, 32'd1);
    chk($sformatf("v%0d ready_other", i), {31'd0, v.g ? r0_ready : r1_ready}, 32'd0);
    step();
    if (v.g) r1_valid = 1'b0; else r0_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d exec_alu_op", i), {29'd0, alu_op}, {29'd0, exp_op});
    chk($sformatf("v%0d exec_alu_a", i), alu_a, exp_a);
    chk($sformatf("v%0d exec_resp_valid", i), {31'd0, v.g ? r1_resp_valid : r0_resp_valid}, 32'd0);
    chk($sformatf("v%0d exec_ready", i), {30'd0, r1_ready, r0_ready}, 32'd0);
    step();
    @(negedge clk);
    chk($sformatf("v%0d resp_valid", i), {31'd0, v.g ? r1_resp_valid : r0_resp_valid}, 32'd1);
    chk($sformatf("v%0d result", i), v.g ? r1_result : r0_result, v.res);
    chk($sformatf("v%0d zero", i), {31'd0, v.g ? r1_zero : r0_zero}, {31'd0, v.z});
    chk($sformatf("v%0d other_resp_valid", i), {31'd0, v.g ? r0_resp_valid : r1_resp_valid}, 32'd0);
    chk($sformatf("v%0d other_result", i), v.g ? r0_result : r1_result, last_res[v.g ? 0 : 1]);
    chk($sformatf("v%0d resp_ready_low", i), {30'd0, r1_ready, r0_ready}, 32'd0);
`ifdef ALU_OPCHECK_EN
    chk($sformatf("v%0d err", i), {31'd0, v.g ? r1_err : r0_err}, {31'd0, v.err});
`endif
    if (v.g) r1_resp_ready = 1'b1; else r0_resp_ready = 1'b1;
    step();
    r0_resp_ready = 1'b0; r1_resp_ready = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    last_res[v.g ? 1 : 0] = v.res;
    @(negedge clk);
    chk($sformatf("v%0d resp_cleared", i), {31'd0, v.g ? r1_resp_valid : r0_resp_valid}, 32'd0);
    chk($sformatf("v%0d result_retained", i), v.g ? r1_result : r0_result, v.res);
    chk($sformatf("v%0d alu_op_idle", i), {29'd0, alu_op}, 32'd0);
    step();
  endtask

  initial begin
    checks = 0; failures = 0;
    last_res[0] = 32'd0; last_res[1] = 32'd0;
    reset = 1'b1;
    r0_valid = 1'b0; r0_op = 3'b000; r0_a = 32'd0; r0_b = 32'd0; r0_resp_ready = 1'b0;
    r1_valid = 1'b0; r1_op = 3'b000; r1_a = 32'd0; r1_b = 32'd0; r1_resp_ready = 1'b0;

    //           v0    v1    op0     op1     a0            b0            a1            b1            g     res           z     err
    tbl[0]  = '{1'b1, 1'b1, 3'b111, 3'b010, 32'd3,        32'd8,        32'hF0,       32'h0F,       1'b0, 32'd1,        1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 3'b111, 3'b010, 32'd3,        32'd8,        32'hF0,       32'h0F,       1'b1, 32'hFF,       1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 3'b111, 3'b010, 32'd3,        32'd8,        32'hF0,       32'h0F,       1'b0, 32'd1,        1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 3'b111, 3'b010, 32'd3,        32'd8,        32'hF0,       32'h0F,       1'b1, 32'hFF,       1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 3'b001, 3'b000, 32'd5,        32'd7,        32'd0,        32'd0,        1'b0, 32'd12,       1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 3'b000, 3'b101, 32'd0,        32'd0,        32'd9,        32'd9,        1'b1, 32'd0,        1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 3'b001, 3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b0, 32'd0,        1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3'b000, 3'b101, 32'd0,        32'd0,        32'd3,        32'd5,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 3'b111, 3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b0, 32'd0,        1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 3'b000, 3'b111, 32'd0,        32'd0,        32'd1,        32'hFFFFFFFF, 1'b1, 32'd1,        1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 3'b011, 3'b000, 32'd6,        32'd6,        32'd0,        32'd0,        1'b0, 32'd0,        1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 3'b001, 3'b000, 32'd2,        32'd3,        32'd0,        32'd0,        1'b0, 32'd5,        1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 3'b010, 3'b001, 32'd1,        32'd2,        32'h7FFFFFFF, 32'd1,        1'b1, 32'h80000000, 1'b0, 1'b0};

    step(); step();
    @(negedge clk);
    chk("rst alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst resp_valid", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
    chk("rst r0_result", r0_result, 32'd0);
    chk("rst r1_result", r1_result, 32'd0);
    chk("rst zero", {30'd0, r1_zero, r0_zero}, 32'd0);
    step();
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_txn(i);

    // Response held while resp_ready is low; r1 waits even in the consume cycle.
    r0_valid = 1'b1; r0_op = 3'b001; r0_a = 32'd1; r0_b = 32'd1;
    r1_valid = 1'b1; r1_op = 3'b010; r1_a = 32'd3; r1_b = 32'd4;
    @(negedge clk);
    chk("stall r0_ready", {31'd0, r0_ready}, 32'd1);
    chk("stall r1_ready_accept", {31'd0, r1_ready}, 32'd0);
    step();
    r0_valid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d resp_valid", k), {31'd0, r0_resp_valid}, 32'd1);
      chk($sformatf("stall%0d result", k), r0_result, 32'd2);
      chk($sformatf("stall%0d r1_ready", k), {31'd0, r1_ready}, 32'd0);
      step();
    end
    @(negedge clk);
    r0_resp_ready = 1'b1;
    chk("stall consume r1_ready", {31'd0, r1_ready}, 32'd0);
    step();
    r0_resp_ready = 1'b0;
    @(negedge clk);
    chk("stall next r1_ready", {31'd0, r1_ready}, 32'd1);
    chk("stall r0_resp_cleared", {31'd0, r0_resp_valid}, 32'd0);
    chk("stall r0_result_kept", r0_result, 32'd2);
    step();
    r1_valid = 1'b0;
    step();
    @(negedge clk);
    chk("stall r1_result", r1_result, 32'd7);
    chk("stall r1_resp_valid", {31'd0, r1_resp_valid}, 32'd1);
    r1_resp_ready = 1'b1;
    step();
    r1_resp_ready = 1'b0;

    // resp_ready with nothing pending has no effect.
    r0_resp_ready = 1'b1; r1_resp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("idle rr resp_valid", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
    chk("idle rr alu_op", {29'd0, alu_op}, 32'd0);
    chk("idle rr r0_result", r0_result, 32'd2);
    step();
    r0_resp_ready = 1'b0; r1_resp_ready = 1'b0;

    // Reset while the operation is in EXEC drops it.
    r1_valid = 1'b1; r1_op = 3'b001; r1_a = 32'd4; r1_b = 32'd4;
    @(negedge clk);
    chk("rexec r1_ready", {31'd0, r1_ready}, 32'd1);
    step();
    r1_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rexec inflight alu_op", {29'd0, alu_op}, 32'd1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rexec resp_valid", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
    chk("rexec alu_op", {29'd0, alu_op}, 32'd0);
    chk("rexec alu_a", alu_a, 32'd0);
    chk("rexec r1_result", r1_result, 32'd0);
    chk("rexec r0_result", r0_result, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk($sformatf("rexec%0d no_resp", k), {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
    end
    step();
    r0_valid = 1'b1; r1_valid = 1'b1;
    @(negedge clk);
    chk("rexec rr r0_first", {30'd0, r1_ready, r0_ready}, 32'd1);
    step();
    r0_valid = 1'b0; r1_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
